// File: rtl/icache_ctrl.sv
// ----------------------------------------------------------------------------
// icache_ctrl -- L1 instruction-cache controller (2-way, 256 sets, 16 B lines)
//
// Performs the zero-latency hit lookup for the fetch stage against the
// asynchronously read tag_ram/data_ram pair. On a miss it fetches the line
// from L2, writes it into the way chosen by the replacement bit, waits for the
// RAM's completion pulse and then returns to IDLE, where the fetch now hits.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   if_req, if_addr       fetch request and byte address
//   if_insn, if_stall     fetched word (valid when if_req && !if_stall), stall
//   tag0_rw/tag1_rw       tag way write strobes   (1 = write, 0 = read)
//   data0_rw/data1_rw     data way write strobes  (1 = write, 0 = read)
//   index                 RAM set index
//   tag_wd, data_wd       tag / line write data
//   tag0_rd/tag1_rd       {valid, tag} read data per way
//   data0_rd/data1_rd     line read data per way
//   LUR                   replacement bit: 1 = next victim is way1
//   complete              one-cycle pulse the cycle after a tag write
//   l2_req, l2_addr       line request and line address to L2
//   l2_ack, l2_data       one-cycle acknowledge with the refill line
//
// Optional feature (macro ICACHE_STAT_EN): adds hit_cnt / miss_cnt outputs.
// ----------------------------------------------------------------------------
module icache_ctrl #(
  parameter int TAG_W   = 20,
  parameter int INDEX_W = 8,
  parameter int LINE_W  = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_insn,
  output logic               if_stall,
  output logic               tag0_rw,
  output logic               tag1_rw,
  output logic               data0_rw,
  output logic               data1_rw,
  output logic [INDEX_W-1:0] index,
  output logic [TAG_W-1:0]   tag_wd,
  output logic [LINE_W-1:0]  data_wd,
  input  logic [TAG_W:0]     tag0_rd,
  input  logic [TAG_W:0]     tag1_rd,
  input  logic [LINE_W-1:0]  data0_rd,
  input  logic [LINE_W-1:0]  data1_rd,
  input  logic               LUR,
  input  logic               complete,
  output logic               l2_req,
  output logic [27:0]        l2_addr,
  input  logic               l2_ack,
  input  logic [LINE_W-1:0]  l2_data
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  localparam int  OFF_W    = 4;              // 16 B line
  localparam int  IDX_LO   = OFF_W;
  localparam int  TAG_LO   = OFF_W + INDEX_W;
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_WAIT
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [31:OFF_W]    r_miss_line;   // miss address without the byte offset
  logic               r_victim;
  logic [LINE_W-1:0]  r_line_buf;

  logic               w_hit0;
  logic               w_hit1;
  logic               w_hit;
  logic               w_miss_start;
  logic [1:0]         w_word;
  logic               w_unused_bits;

  // --------------------------------------------------------------------------
  // Hit lookup (only meaningful in IDLE, where index comes from if_addr)
  // --------------------------------------------------------------------------
  assign w_hit0       = tag0_rd[TAG_W] && (tag0_rd[TAG_W-1:0] == if_addr[31:TAG_LO]);
  assign w_hit1       = tag1_rd[TAG_W] && (tag1_rd[TAG_W-1:0] == if_addr[31:TAG_LO]);
  assign w_hit        = w_hit0 || w_hit1;
  assign w_miss_start = if_req && !w_hit;
  assign w_word       = if_addr[3:2];
  assign w_unused_bits = ^if_addr[1:0];

  // Way0 has priority should both ways ever hold the same tag.
  always_comb begin
    if_insn = '0;
    if (r_state == S_IDLE) begin
      if (w_hit0)      if_insn = data0_rd[w_word*32 +: 32];
      else if (w_hit1) if_insn = data1_rd[w_word*32 +: 32];
    end
  end

  // --------------------------------------------------------------------------
  // State and refill registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_miss_line <= '0;
      r_victim    <= 1'b0;
      // NOTE: the line buffer is a plain register (not a RAM), so clearing it
      // on reset is cheap and keeps data_wd deterministic after reset.
      r_line_buf  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && w_miss_start) begin
        r_miss_line <= if_addr[31:OFF_W];
        r_victim    <= LUR;
      end
      if (r_state == S_REQ && l2_ack) begin
        r_line_buf <= l2_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    w_next_state = r_state;
    l2_req       = 1'b0;
    l2_addr      = r_miss_line;
    tag0_rw      = RW_READ;
    tag1_rw      = RW_READ;
    data0_rw     = RW_READ;
    data1_rw     = RW_READ;
    index        = r_miss_line[TAG_LO-1:IDX_LO];
    tag_wd       = r_miss_line[31:TAG_LO];
    data_wd      = r_line_buf;
    if_stall     = 1'b1;

    case (r_state)
      S_IDLE: begin
        index    = if_addr[TAG_LO-1:IDX_LO];
        if_stall = w_miss_start;
        if (w_miss_start) w_next_state = S_REQ;
      end
      S_REQ: begin
        l2_req = 1'b1;
        if (l2_ack) w_next_state = S_WRITE;
      end
      S_WRITE: begin
        if (r_victim) begin
          tag1_rw  = RW_WRITE;
          data1_rw = RW_WRITE;
        end else begin
          tag0_rw  = RW_WRITE;
          data0_rw = RW_WRITE;
        end
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (complete) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

`ifdef ICACHE_STAT_EN
  // --------------------------------------------------------------------------
  // Hit / miss statistics (wrap naturally at 2^32)
  // --------------------------------------------------------------------------
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && if_req && w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (r_state == S_IDLE && w_miss_start)    r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// ----------------------------------------------------------------------------
// tb_icache_ctrl -- scoreboard bench for icache_ctrl
//
// Models the 2-way tag/data RAM (asynchronous read, write at the clock edge,
// complete pulse one cycle after a tag write) and an L2 that acknowledges a
// programmable number of cycles after l2_req rises. Directed fetches push
// their expected instruction, stall count, L2 line address and RAM write into
// queues; independent monitors pop and compare when the DUT presents them.
// Build with +define+ICACHE_STAT_EN to also exercise the statistics counters.
// ----------------------------------------------------------------------------
module tb_icache_ctrl;

  localparam logic WR = 1'b1;

  localparam logic [127:0] LINE_A = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
  localparam logic [127:0] LINE_B = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] LINE_C = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
  localparam logic [127:0] LINE_D = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
  localparam logic [127:0] LINE_E = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};
  localparam logic [127:0] LINE_F = {32'hF3F3F3F3, 32'hF2F2F2F2, 32'hF1F1F1F1, 32'hF0F0F0F0};

  logic         clk = 1'b0;
  logic         rst;
  logic         if_req;
  logic [31:0]  if_addr;
  logic [31:0]  if_insn;
  logic         if_stall;
  logic         tag0_rw, tag1_rw, data0_rw, data1_rw;
  logic [7:0]   index;
  logic [19:0]  tag_wd;
  logic [127:0] data_wd;
  logic [20:0]  tag0_rd, tag1_rd;
  logic [127:0] data0_rd, data1_rd;
  logic         LUR;
  logic         complete;
  logic         l2_req;
  logic [27:0]  l2_addr;
  logic         l2_ack;
  logic [127:0] l2_data;
`ifdef ICACHE_STAT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_insn  (if_insn),
    .if_stall (if_stall),
    .tag0_rw  (tag0_rw),
    .tag1_rw  (tag1_rw),
    .data0_rw (data0_rw),
    .data1_rw (data1_rw),
    .index    (index),
    .tag_wd   (tag_wd),
    .data_wd  (data_wd),
    .tag0_rd  (tag0_rd),
    .tag1_rd  (tag1_rd),
    .data0_rd (data0_rd),
    .data1_rd (data1_rd),
    .LUR      (LUR),
    .complete (complete),
`ifdef ICACHE_STAT_EN
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
`endif
    .l2_req   (l2_req),
    .l2_addr  (l2_addr),
    .l2_ack   (l2_ack),
    .l2_data  (l2_data)
  );

  // --------------------------------------------------------------------------
  // Check bookkeeping
  // --------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard queues
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] stalls;
  } fetch_exp_t;

  typedef struct packed {
    logic         way;
    logic [7:0]   idx;
    logic [19:0]  tag;
    logic [127:0] data;
  } wr_exp_t;

  fetch_exp_t   q_fetch[$];
  wr_exp_t      q_wr[$];
  logic [27:0]  q_l2[$];
  logic [127:0] q_lines[$];   // lines the L2 model returns, in order

  // --------------------------------------------------------------------------
  // Tag/data RAM model
  // --------------------------------------------------------------------------
  logic [19:0]  t_ram [2][256];
  logic         v_ram [2][256];
  logic [127:0] d_ram [2][256];

  assign tag0_rd  = {v_ram[0][index], t_ram[0][index]};
  assign tag1_rd  = {v_ram[1][index], t_ram[1][index]};
  assign data0_rd = d_ram[0][index];
  assign data1_rd = d_ram[1][index];

  initial begin
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 256; i++) begin
        t_ram[w][i] = '0;
        v_ram[w][i] = 1'b0;
        d_ram[w][i] = '0;
      end
  end

  initial begin
    complete = 1'b0;
    forever begin
      @(posedge clk);
      if (tag0_rw == WR)  begin t_ram[0][index] <= tag_wd; v_ram[0][index] <= 1'b1; end
      if (tag1_rw == WR)  begin t_ram[1][index] <= tag_wd; v_ram[1][index] <= 1'b1; end
      if (data0_rw == WR) d_ram[0][index] <= data_wd;
      if (data1_rw == WR) d_ram[1][index] <= data_wd;
      complete <= (tag0_rw == WR) || (tag1_rw == WR);
    end
  end

  // --------------------------------------------------------------------------
  // L2 model: acknowledges after l2_delay full cycles of l2_req
  // --------------------------------------------------------------------------
  int   l2_delay = 1;
  logic l2_auto  = 1'b1;

  initial begin
    int req_cycles;
    req_cycles = 0;
    l2_ack  = 1'b0;
    l2_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (l2_auto) begin
        if (l2_req) begin
          if (req_cycles >= l2_delay) begin
            l2_ack  = 1'b1;
            l2_data = (q_lines.size() != 0) ? q_lines.pop_front() : '0;
          end else begin
            l2_ack = 1'b0;
          end
          req_cycles++;
        end else begin
          req_cycles = 0;
          l2_ack     = 1'b0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitors (sample on the falling edge)
  // --------------------------------------------------------------------------
  initial begin : mon_fetch
    int stall_cnt;
    fetch_exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0;
      end else if (if_req) begin
        if (if_stall) begin
          stall_cnt++;
        end else if (q_fetch.size() == 0) begin
          fail_now("unexpected_fetch");
        end else begin
          e = q_fetch.pop_front();
          check("fetch_insn", 128'(if_insn), 128'(e.insn));
          check("fetch_stalls", 128'(stall_cnt), 128'(e.stalls));
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin : mon_wr
    wr_exp_t e;
    logic [3:0] exp_strb;
    forever begin
      @(negedge clk);
      if (tag0_rw || tag1_rw || data0_rw || data1_rw) begin
        if (q_wr.size() == 0) begin
          fail_now("unexpected_ram_write");
        end else begin
          e = q_wr.pop_front();
          exp_strb = e.way ? 4'b0011 : 4'b1100;
          check("wr_strobes", 128'({tag0_rw, data0_rw, tag1_rw, data1_rw}), 128'(exp_strb));
          check("wr_index", 128'(index), 128'(e.idx));
          check("wr_tag", 128'(tag_wd), 128'(e.tag));
          check("wr_data", data_wd, e.data);
        end
      end
    end
  end

  initial begin : mon_l2
    logic prev;
    logic [27:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (l2_req && !prev) begin
        if (q_l2.size() == 0) begin
          fail_now("unexpected_l2_req");
        end else begin
          e = q_l2.pop_front();
          check("l2_addr", 128'(l2_addr), 128'(e));
        end
      end
      prev = l2_req;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic exp_fetch(input logic [31:0] insn, input int stalls);
    fetch_exp_t e;
    e.insn   = insn;
    e.stalls = 32'(stalls);
    q_fetch.push_back(e);
  endtask

  task automatic exp_refill(input logic [27:0] line_addr, input logic way,
                            input logic [127:0] line);
    wr_exp_t e;
    e.way  = way;
    e.idx  = line_addr[7:0];
    e.tag  = line_addr[27:8];
    e.data = line;
    q_l2.push_back(line_addr);
    q_wr.push_back(e);
    q_lines.push_back(line);
  endtask

  // Wait (bounded) until the current fetch is accepted, then move to the
  // start of the next cycle.
  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (if_stall && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (if_stall) fail_now("fetch_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] insn, input int stalls);
    exp_fetch(insn, stalls);
    if_req  = 1'b1;
    if_addr = addr;
    wait_accept();
  endtask

  task automatic wait_l2_req();
    int n;
    n = 0;
    while (!l2_req && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!l2_req) fail_now("l2_req_timeout");
  endtask

  task automatic idle(input int cycles);
    if_req = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    rst     = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    LUR     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_l2_req", 128'(l2_req), 128'(0));
    check("rst_strobes", 128'({tag0_rw, tag1_rw, data0_rw, data1_rw}), 128'(0));
    check("rst_stall_idle", 128'(if_stall), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Cold miss, way0, ack one cycle after l2_req rises: 5 stall cycles.
    LUR      = 1'b0;
    l2_delay = 1;
    exp_refill(28'h0000123, 1'b0, LINE_A);
    fetch(32'h0000_1234, 32'hBBBBBBBB, 5);

    // Hit stream over the whole line.
    fetch(32'h0000_1230, 32'hAAAAAAAA, 0);
    fetch(32'h0000_1234, 32'hBBBBBBBB, 0);
    fetch(32'h0000_1238, 32'hCCCCCCCC, 0);
    fetch(32'h0000_123C, 32'hDDDDDDDD, 0);

    // Second way of the same set.
    LUR = 1'b1;
    exp_refill(28'h0000223, 1'b1, LINE_B);
    fetch(32'h0000_2230, 32'h11111111, 5);
    fetch(32'h0000_1234, 32'hBBBBBBBB, 0);
    fetch(32'h0000_223C, 32'h44444444, 0);

    // Ack in the very cycle l2_req rises: 4 stall cycles.
    l2_delay = 0;
    exp_refill(28'h0000567, 1'b1, LINE_C);
    fetch(32'h0000_5678, 32'hC2C2C2C2, 4);

    // Address change during refill: first refill completes, then new miss.
    LUR      = 1'b0;
    l2_delay = 2;
    exp_refill(28'h0000145, 1'b0, LINE_F);
    exp_refill(28'h8000000, 1'b0, LINE_D);
    exp_fetch(32'hD0D0D0D0, 12);
    if_req  = 1'b1;
    if_addr = 32'h0000_1450;
    wait_l2_req();
    if_addr = 32'h8000_0000;
    wait_accept();
    fetch(32'h0000_1454, 32'hF1F1F1F1, 0);

    // Both ways holding the same tag: way0 wins.
    t_ram[0][8'h77] = 20'h00007; v_ram[0][8'h77] = 1'b1;
    d_ram[0][8'h77] = {32'h0, 32'h0, 32'h5A5A5A5A, 32'h0};
    t_ram[1][8'h77] = 20'h00007; v_ram[1][8'h77] = 1'b1;
    d_ram[1][8'h77] = {32'h0, 32'h0, 32'hA5A5A5A5, 32'h0};
    fetch(32'h0000_7774, 32'h5A5A5A5A, 0);
    idle(1);

    // Reset while in REQ: no write, l2_req drops at that edge.
    l2_delay = 5;
    q_l2.push_back(28'h0000ABC);
    if_req  = 1'b1;
    if_addr = 32'h0000_ABC0;
    wait_l2_req();
    rst    = 1'b1;
    if_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstreq_l2_req", 128'(l2_req), 128'(0));
    check("rstreq_strobes", 128'({tag0_rw, tag1_rw, data0_rw, data1_rw}), 128'(0));
    rst = 1'b0;
    // Stray acknowledge while IDLE must not cause a write or a request.
    l2_auto = 1'b0;
    @(posedge clk);
    #1;
    l2_ack  = 1'b1;
    l2_data = {4{32'h12345678}};
    @(posedge clk);
    #1;
    l2_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stray_ack_l2_req", 128'(l2_req), 128'(0));
    @(posedge clk);
    #1;
    l2_auto  = 1'b1;
    l2_delay = 1;

`ifdef ICACHE_STAT_EN
    check("stat_rst_hit", 128'(hit_cnt), 128'(0));
    check("stat_rst_miss", 128'(miss_cnt), 128'(0));
    LUR = 1'b0;
    exp_refill(28'h0000399, 1'b0, LINE_E);
    fetch(32'h0000_3990, 32'hE0E0E0E0, 5);
    fetch(32'h0000_3994, 32'hE1E1E1E1, 0);
    fetch(32'h0000_3998, 32'hE2E2E2E2, 0);
    fetch(32'h0000_399C, 32'hE3E3E3E3, 0);
    idle(2);
    check("stat_hit_cnt", 128'(hit_cnt), 128'(4));
    check("stat_miss_cnt", 128'(miss_cnt), 128'(1));
    force dut.r_hit_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_hit_cnt;
    fetch(32'h0000_3990, 32'hE0E0E0E0, 0);
    idle(1);
    check("stat_hit_wrap", 128'(hit_cnt), 128'(0));
`endif

    idle(5);
    check("fetch_q_empty", 128'(q_fetch.size()), 128'(0));
    check("wr_q_empty", 128'(q_wr.size()), 128'(0));
    check("l2_q_empty", 128'(q_l2.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
